dl_pipe_skid: RTL

DL_PIPE_SKID -- requirements
Module: dl_pipe_skid

---
 rtl/dl_pipe_skid.sv | 95 +++++++++
 1 files changed

// File: rtl/dl_pipe_skid.sv
// Two-entry pipeline register with a skid buffer: full throughput, and in_ready
// is decoded from state flops only so there is no combinational ready path.
module dl_pipe_skid #(
  parameter int unsigned           NUM_BITS = 32,
  parameter logic [NUM_BITS-1:0]   RST_VAL  = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BITS-1:0] out_data,
  output logic [1:0]          count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] main_q, main_d;
  logic [NUM_BITS-1:0] skid_q, skid_d;
  logic                in_fire;
  logic                out_fire;

  // Handshake flags derived from registered state only.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    count = 2'd0;
    case (state_q)
      ST_ONE:  count = 2'd1;
      ST_FULL: count = 2'd2;
      default: count = 2'd0;
    endcase
  end

  // Next-state and data-register update.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = ST_FULL;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= RST_VAL;
      skid_q  <= RST_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
